// File: rtl/router_pkg.sv
// Shared types and sizes for the router output port slice.
package router_pkg;

  localparam int unsigned WORD_W      = 3;
  localparam int unsigned TIMEOUT_DEF = 30;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STALL_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY
  } state_t;

endpackage

// File: rtl/router_stall_timer.sv
// Counts consecutive stalled cycles; expired fires on the TIMEOUT-th one.
module router_stall_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic stall,
  input  logic clear,
  output logic expired
);

  logic [STALL_W-1:0] count;

  assign expired = stall && (count == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!resetn || clear || expired)
      count <= '0;
    else if (stall)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/router_out_port.sv
// Output port of the router: fetches a packet from router_fifo, presents it
// word by word to the destination, checks parity and recovers from stalls.
module router_out_port
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              dest_read,
  output logic              fifo_read_enb,
  output logic              vld_out,
  output logic [WORD_W-1:0] data_out,
  output logic              soft_reset,
  output logic              pkt_done,
  output logic              parity_err
);

  state_t            state_q, state_d;
  logic              rd_pending;
  logic [CNT_W-1:0]  fetch_left;
  logic [CNT_W-1:0]  deliver_left;
  logic [WORD_W-1:0] parity_acc;
  logic              delivery, stall, fetch_ok, expired, hdr_cap;

  router_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clock   (clock),
    .resetn  (resetn),
    .stall   (stall),
    .clear   (delivery | ~vld_out),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    delivery = vld_out & dest_read;
    stall    = vld_out & ~dest_read;
    hdr_cap  = rd_pending && (state_q == HEADER);
    fetch_ok = (state_q == IDLE) ? 1'b1 : (fetch_left != '0);
    // soft_reset gate keeps IDLE from grabbing a header while the fifo flushes
    fifo_read_enb = resetn & ~soft_reset & ~fifo_empty & ~rd_pending &
                    fetch_ok & (~vld_out | dest_read);
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fifo_read_enb) state_d = HEADER;
      HEADER:  if (delivery) state_d = PAYLOAD;
      PAYLOAD: if (delivery && deliver_left == CNT_W'(1)) state_d = PARITY;
      PARITY:  if (delivery) state_d = IDLE;
    endcase
    if (expired) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_pending   <= 1'b0;
      vld_out      <= 1'b0;
      data_out     <= '0;
      fetch_left   <= '0;
      deliver_left <= '0;
      parity_acc   <= '0;
      soft_reset   <= 1'b0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
    end else if (expired) begin
      rd_pending   <= 1'b0;
      vld_out      <= 1'b0;
      fetch_left   <= '0;
      deliver_left <= '0;
      parity_acc   <= '0;
      soft_reset   <= 1'b1;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      rd_pending <= fifo_read_enb;
      pkt_done   <= (state_q == PARITY) && delivery;
      parity_err <= (state_q == PARITY) && delivery && (parity_acc != data_out);

      if (rd_pending) begin
        data_out <= fifo_data;
        vld_out  <= 1'b1;
      end else if (delivery) begin
        vld_out <= 1'b0;
      end

      // the IDLE header fetch is implicit and does not consume fetch_left
      if (hdr_cap)
        fetch_left <= CNT_W'(fifo_data) + CNT_W'(2);
      else if (fifo_read_enb && state_q != IDLE)
        fetch_left <= fetch_left - 1'b1;

      if (hdr_cap)
        deliver_left <= CNT_W'(fifo_data) + CNT_W'(1);
      else if (delivery && state_q == PAYLOAD)
        deliver_left <= deliver_left - 1'b1;

      if (delivery && state_q == PARITY)
        parity_acc <= '0;
      else if (delivery && (state_q == HEADER || state_q == PAYLOAD))
        parity_acc <= parity_acc ^ data_out;
    end
  end

endmodule

// File: tb/tb_router_out_port.sv
// Scoreboard bench for router_out_port with a behavioural router_fifo model.
module tb_router_out_port;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       fifo_empty;
  logic [2:0] fifo_data = 3'd0;
  logic       dest_read = 1'b0;
  logic       fifo_read_enb, vld_out, soft_reset, pkt_done, parity_err;
  logic [2:0] data_out;

  logic [2:0] fmem [256];
  logic [7:0] rd_idx = 8'd0;
  logic [7:0] wr_idx = 8'd0;
  logic       fifo_hold = 1'b0;

  logic [2:0] exp_q [$];
  bit         err_q [$];
  int checks = 0, errors = 0;
  int sr_count = 0, rd_count = 0;

  assign fifo_empty = fifo_hold || (rd_idx == wr_idx);

  always #5 clock = ~clock;

  router_out_port #(.TIMEOUT(30)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .dest_read     (dest_read),
    .fifo_read_enb (fifo_read_enb),
    .vld_out       (vld_out),
    .data_out      (data_out),
    .soft_reset    (soft_reset),
    .pkt_done      (pkt_done),
    .parity_err    (parity_err)
  );

  // router_fifo model: data appears the cycle after the read strobe; flushed on reset/soft_reset
  always @(posedge clock) begin
    if (!resetn || soft_reset)
      rd_idx <= wr_idx;
    else if (fifo_read_enb) begin
      fifo_data <= fmem[rd_idx];
      rd_idx    <= rd_idx + 8'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clock) begin
    if (resetn) begin
      if (fifo_read_enb) rd_count++;
      if (soft_reset) begin
        sr_count++;
        check("no_fetch_in_soft_reset", int'(fifo_read_enb), 0);
      end
      if (vld_out && dest_read) begin
        check("delivery_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("delivery_data", int'(data_out), int'(exp_q.pop_front()));
      end
      if (pkt_done) begin
        check("pkt_done_expected", int'(err_q.size() != 0), 1);
        check("pkt_done_after_last_word", exp_q.size(), 0);
        if (err_q.size() != 0) check("parity_err", int'(parity_err), int'(err_q.pop_front()));
      end else begin
        check("parity_err_without_pkt_done", int'(parity_err), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [2:0] w, input bit expect_it);
    fmem[wr_idx] = w;
    wr_idx = wr_idx + 8'd1;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check(name, exp_q.size() + err_q.size(), 0);
  endtask

  initial begin
    int n, guard;

    // reset: outputs clear, no fetch while resetn is low even with data available
    repeat (2) tick();
    push_word(3'd5, 1'b0);
    @(negedge clock);
    check("reset_fifo_read_enb", int'(fifo_read_enb), 0);
    check("reset_vld_out", int'(vld_out), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_soft_reset", int'(soft_reset), 0);
    check("reset_pkt_done", int'(pkt_done), 0);
    check("reset_parity_err", int'(parity_err), 0);
    tick();
    resetn = 1'b1;
    tick();

    // good parity: 1 ^ 5 ^ 2 = 6
    rd_count = 0;
    dest_read = 1'b1;
    push_word(3'd1, 1'b1); push_word(3'd5, 1'b1); push_word(3'd2, 1'b1); push_word(3'd6, 1'b1);
    err_q.push_back(1'b0);
    drain("pkt_good_drain", 100);
    check("pkt_good_fetches", rd_count, 4);

    // bad parity word 0
    rd_count = 0;
    push_word(3'd1, 1'b1); push_word(3'd5, 1'b1); push_word(3'd2, 1'b1); push_word(3'd0, 1'b1);
    err_q.push_back(1'b1);
    drain("pkt_bad_drain", 100);
    check("pkt_bad_fetches", rd_count, 4);

    // header presented, never accepted: soft reset after exactly 30 stalled cycles
    rd_count = 0; sr_count = 0;
    dest_read = 1'b0;
    push_word(3'd1, 1'b0); push_word(3'd5, 1'b0); push_word(3'd2, 1'b0); push_word(3'd6, 1'b0);
    n = 0; guard = 0;
    while (!soft_reset && guard < 100) begin
      @(negedge clock);
      if (vld_out) n++;
      guard++;
    end
    check("timeout_stall_cycles", n, 30);
    check("timeout_vld_out", int'(vld_out), 0);
    repeat (10) tick();
    check("timeout_single_pulse", sr_count, 1);
    check("timeout_only_header_fetched", rd_count, 1);

    // 29 stalled cycles on the header, then 29 on the first payload word: no timeout
    sr_count = 0; rd_count = 0;
    push_word(3'd1, 1'b1); push_word(3'd5, 1'b1); push_word(3'd2, 1'b1); push_word(3'd6, 1'b1);
    err_q.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while (!vld_out && guard < 50) begin tick(); guard++; end
      check("stall29_word_presented", int'(vld_out), 1);
      repeat (29) tick();
      dest_read = 1'b1;
      tick();
      dest_read = 1'b0;
    end
    dest_read = 1'b1;
    drain("stall29_drain", 100);
    check("stall29_no_soft_reset", sr_count, 0);
    check("stall29_fetches", rd_count, 4);

    // longest packet with an intermittently empty fifo: 7 ^ (3^6^1^4^7^2^5^0) = 7
    rd_count = 0;
    push_word(3'd7, 1'b1);
    push_word(3'd3, 1'b1); push_word(3'd6, 1'b1); push_word(3'd1, 1'b1); push_word(3'd4, 1'b1);
    push_word(3'd7, 1'b1); push_word(3'd2, 1'b1); push_word(3'd5, 1'b1); push_word(3'd0, 1'b1);
    push_word(3'd7, 1'b1);
    err_q.push_back(1'b0);
    n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 300) begin
      fifo_hold = (n % 3 == 1);
      tick();
      n++;
    end
    fifo_hold = 1'b0;
    drain("long_pkt_drain", 10);
    check("long_pkt_fetches", rd_count, 10);
    check("long_pkt_no_soft_reset", sr_count, 0);

    // reset in the middle of the payload, then a fresh L=0 packet: 0 ^ 5 = 5
    push_word(3'd3, 1'b1); push_word(3'd1, 1'b1); push_word(3'd2, 1'b1);
    push_word(3'd3, 1'b1); push_word(3'd4, 1'b1); push_word(3'd7, 1'b1);
    err_q.push_back(1'b0);
    guard = 0;
    while (exp_q.size() > 3 && guard < 100) begin tick(); guard++; end
    check("midpkt_progress", int'(exp_q.size() <= 3), 1);
    resetn = 1'b0;
    exp_q.delete();
    err_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("midreset_vld_out", int'(vld_out), 0);
    check("midreset_data_out", int'(data_out), 0);
    check("midreset_pkt_done", int'(pkt_done), 0);
    check("midreset_parity_err", int'(parity_err), 0);
    check("midreset_soft_reset", int'(soft_reset), 0);
    check("midreset_fifo_read_enb", int'(fifo_read_enb), 0);
    tick();
    resetn = 1'b1;
    tick();
    rd_count = 0;
    push_word(3'd0, 1'b1); push_word(3'd5, 1'b1); push_word(3'd5, 1'b1);
    err_q.push_back(1'b0);
    drain("post_reset_drain", 100);
    check("post_reset_fetches", rd_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
